spi_cmd_parser: RTL and testbench
=================================

Name: spi_cmd_parser

Overview:
- Byte-level command layer directly downstream of the SPI slave.
- Consumes the slave's received-byte strobe and data, and drives the slave's next-transmit byte.
- Assembles a work block for the hashing core and returns status and found-nonce bytes to the SPI master.
- One SPI frame (ss low) carries exactly one command.

Parameters:
WORK_BYTES, 44, payload length of WRITE_WORK in bytes (midstate + tail data); legal range 1..255.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
ss  in  1  raw SPI slave-select, active low; double-flop synchronised internally
rx_done  in  1  one-cycle strobe: byte received by SPI slave
rx_data  in  8  received byte, valid with rx_done
tx_data  out  8  byte offered to SPI slave for transmission
busy  in  1  hashing core busy, reported in status
nonce_valid  in  1  one-cycle strobe from core: nonce found
nonce  in  32  found nonce, valid with nonce_valid
work_valid  out  1  one-cycle pulse: work_data complete
work_data  out  WORK_BYTES*8  assembled work; first received byte in the MSBs
found  out  1  nonce waiting to be read (interrupt line)

Behaviour:
- Reset values: tx_data = status byte (0x05), work_valid 0, work_data 0, found 0, internal nonce 0, overrun 0, csum_err 0, state IDLE, byte_cnt 0.
- Status byte layout: [7] found, [6] busy, [5] overrun, [4] csum_err, [3:0] 4'h5 signature.
- Frame index k counts rx_done strobes since the synchronised ss fell.
  - k=0 is the command byte.
- tx_data is registered and updated in the cycle after each rx_done.
- The SPI slave latches tx_data on the edge its done strobe rises, and continuously while ss is high.
  - Byte 0 transmits tx_data as it stood before the frame.
  - Byte 1 transmits tx_data as set before byte 0 completed.
  - The tx_data written after byte k is transmitted in byte k+2.
- While synchronised ss is high:
  - state = IDLE, byte_cnt = 0.
  - tx_data tracks the live status byte every cycle.
- State transitions on rx_done:
  - IDLE, cmd 0x01 -> WORK.
  - IDLE, cmd 0x02 -> STAT.
  - IDLE, cmd 0x03 -> NONCE.
  - IDLE, any other cmd -> DRAIN.
- WORK:
  - Each rx_done shifts work_data left by 8 and inserts rx_data in the LSB.
  - byte_cnt increments on each rx_done.
  - After payload byte WORK_BYTES: pulse work_valid for one cycle, then go to DRAIN.
  - Further bytes in the frame are ignored.
- STAT:
  - After cmd byte: tx_data = live status, so bytes 2.. return status.
  - Stays in STAT until ss rises.
- NONCE:
  - After byte k (k=0..3): tx_data = nonce byte k, MSB first, so bytes 2..5 carry the nonce.
  - On rx_done of byte 5: clear found and overrun in the same cycle, then go to DRAIN.
- DRAIN: tx_data = 0xFF; ignore all bytes until ss rises.
- Nonce capture:
  - nonce_valid with found=0 and state != NONCE: latch nonce, set found.
  - Otherwise the nonce is dropped and overrun is set.
  - If nonce_valid coincides with the found-clear cycle, the new nonce is latched and found stays 1. Clear wins for overrun.
- Abort: ss rising mid-WORK returns to IDLE with no work_valid. work_data may hold partial shifts and is meaningful only at work_valid.
- Abort: ss rising mid-NONCE before byte 5 leaves found and nonce unchanged.
- rx_done arriving while ss is synchronised high is ignored.
- Reset asserted mid-frame returns every register to its reset value immediately.

Optional Feature:
- Macro WORK_CSUM_EN.
- Defined:
  - WRITE_WORK takes one extra byte after the payload: the XOR of all WORK_BYTES payload bytes.
  - Match: pulse work_valid and clear csum_err.
  - Mismatch: no work_valid, set csum_err.
  - csum_err is cleared on the next matching WRITE_WORK or by reset.
- Undefined:
  - No checksum byte; work_valid pulses after the last payload byte.
  - Status bit 4 is tied to 0.

Test Plan:
- Reset, ss high, busy=1 -> tx_data=0x45, found=0, work_valid=0; frame cmd 0x02 + 3 dummies -> MISO bytes 0x45,0x45,0x45,0x45.
- WORK_BYTES=4, frame 0x01,0xDE,0xAD,0xBE,0xEF (plus 0xDE^0xAD^0xBE^0xEF=0x22 with WORK_CSUM_EN) -> single work_valid pulse, work_data=0xDEADBEEF.
- Same frame with checksum byte 0x23 (WORK_CSUM_EN) -> no work_valid, next status byte = 0x15 with busy=0.
- nonce_valid with nonce=0x12345678 -> found=1; frame 0x03 + 5 dummies -> bytes 2..5 = 0x12,0x34,0x56,0x78; found=0 after byte 5.
- Two nonce_valid strobes (0xAAAA0001, then 0xBBBB0002) before read -> READ_NONCE returns 0xAAAA0001; status before read = 0xA5.
- ss raised after 2 of 4 payload bytes, then full frame 0x01,0x01,0x02,0x03,0x04 -> no pulse on the aborted frame, then work_valid with work_data=0x01020304.

Source files
------------

// File: rtl/spi_cmd_parser.sv
// Byte-level command layer behind an SPI slave: WRITE_WORK / READ_STATUS / READ_NONCE.
// Define WORK_CSUM_EN to require an XOR checksum byte after the WRITE_WORK payload.
module spi_cmd_parser #(
    parameter int WORK_BYTES = 44
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ss,
    input  logic                    rx_done,
    input  logic [7:0]              rx_data,
    output logic [7:0]              tx_data,
    input  logic                    busy,
    input  logic                    nonce_valid,
    input  logic [31:0]             nonce,
    output logic                    work_valid,
    output logic [WORK_BYTES*8-1:0] work_data,
    output logic                    found
);
    localparam int WW = WORK_BYTES * 8;
    localparam logic [8:0] LAST = 9'(WORK_BYTES);

    typedef enum logic [2:0] {IDLE, WORK, STAT, NONCE, DRAIN} state_t;

    state_t          state_q, state_d;
    logic            ss_meta_q, ss_sync_q;
    logic [8:0]      byte_cnt_q, byte_cnt_d;
    logic [7:0]      tx_q, tx_d;
    logic            work_valid_q, work_valid_d;
    logic [WW-1:0]   work_data_q, work_data_d;
    logic            found_q, found_d;
    logic [31:0]     nonce_q, nonce_d;
    logic            overrun_q, overrun_d;
    logic            nonce_clr;
    logic [7:0]      status;
    logic            csum_err;
`ifdef WORK_CSUM_EN
    logic            csum_err_q, csum_err_d;
    logic [7:0]      csum_q, csum_d;
    assign csum_err = csum_err_q;
`else
    assign csum_err = 1'b0;
`endif

    assign status     = {found_q, busy, overrun_q, csum_err, 4'h5};
    assign tx_data    = tx_q;
    assign work_valid = work_valid_q;
    assign work_data  = work_data_q;
    assign found      = found_q;

    always_comb begin
        state_d      = state_q;
        byte_cnt_d   = byte_cnt_q;
        tx_d         = tx_q;
        work_valid_d = 1'b0;
        work_data_d  = work_data_q;
        found_d      = found_q;
        nonce_d      = nonce_q;
        overrun_d    = overrun_q;
        nonce_clr    = 1'b0;
`ifdef WORK_CSUM_EN
        csum_err_d   = csum_err_q;
        csum_d       = csum_q;
`endif
        if (ss_sync_q) begin
            // Between frames the next byte out is always the live status.
            state_d    = IDLE;
            byte_cnt_d = '0;
            tx_d       = status;
`ifdef WORK_CSUM_EN
            csum_d     = '0;
`endif
        end else if (rx_done) begin
            if (byte_cnt_q != 9'h1FF) byte_cnt_d = byte_cnt_q + 9'd1;
            case (state_q)
                IDLE: begin
                    case (rx_data)
                        8'h01:   begin state_d = WORK;  tx_d = 8'hFF; end
                        8'h02:   begin state_d = STAT;  tx_d = status; end
                        8'h03:   begin state_d = NONCE; tx_d = nonce_q[31:24]; end
                        default: begin state_d = DRAIN; tx_d = 8'hFF; end
                    endcase
                end
                WORK: begin
                    if (byte_cnt_q <= LAST) begin
                        work_data_d      = work_data_q << 8;
                        work_data_d[7:0] = rx_data;
                    end
`ifdef WORK_CSUM_EN
                    if (byte_cnt_q <= LAST) begin
                        csum_d = csum_q ^ rx_data;
                    end else begin
                        state_d = DRAIN;
                        if (rx_data == csum_q) begin
                            work_valid_d = 1'b1;
                            csum_err_d   = 1'b0;
                        end else begin
                            csum_err_d   = 1'b1;
                        end
                    end
`else
                    if (byte_cnt_q == LAST) begin
                        work_valid_d = 1'b1;
                        state_d      = DRAIN;
                    end
`endif
                end
                STAT: tx_d = status;
                NONCE: begin
                    // After byte k the nonce byte k is queued; it goes out in byte k+2.
                    case (byte_cnt_q)
                        9'd1:    tx_d = nonce_q[23:16];
                        9'd2:    tx_d = nonce_q[15:8];
                        9'd3:    tx_d = nonce_q[7:0];
                        9'd5: begin
                            tx_d      = 8'hFF;
                            nonce_clr = 1'b1;
                            state_d   = DRAIN;
                        end
                        default: tx_d = 8'hFF;
                    endcase
                end
                default: tx_d = 8'hFF;
            endcase
        end

        if (nonce_clr) begin
            found_d   = 1'b0;
            overrun_d = 1'b0;
        end
        // A new nonce may land in the very cycle the old one is released.
        if (nonce_valid) begin
            if (nonce_clr || (!found_q && state_q != NONCE)) begin
                nonce_d = nonce;
                found_d = 1'b1;
            end else if (!nonce_clr) begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ss_meta_q    <= 1'b1;
            ss_sync_q    <= 1'b1;
            state_q      <= IDLE;
            byte_cnt_q   <= '0;
            tx_q         <= 8'h05;
            work_valid_q <= 1'b0;
            work_data_q  <= '0;
            found_q      <= 1'b0;
            nonce_q      <= '0;
            overrun_q    <= 1'b0;
`ifdef WORK_CSUM_EN
            csum_err_q   <= 1'b0;
            csum_q       <= '0;
`endif
        end else begin
            ss_meta_q    <= ss;
            ss_sync_q    <= ss_meta_q;
            state_q      <= state_d;
            byte_cnt_q   <= byte_cnt_d;
            tx_q         <= tx_d;
            work_valid_q <= work_valid_d;
            work_data_q  <= work_data_d;
            found_q      <= found_d;
            nonce_q      <= nonce_d;
            overrun_q    <= overrun_d;
`ifdef WORK_CSUM_EN
            csum_err_q   <= csum_err_d;
            csum_q       <= csum_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_cmd_parser.sv
// Directed bench for spi_cmd_parser (WORK_BYTES=4); models the SPI slave's MISO byte latching.
module tb_spi_cmd_parser;
    logic        clk = 1'b0;
    logic        rst_n, ss, rx_done, busy, nonce_valid, work_valid, found;
    logic [7:0]  rx_data, tx_data;
    logic [31:0] nonce, work_data;

    int checks = 0;
    int errors = 0;
    int wv_cnt = 0;
    logic [31:0] wv_data = '0;
    logic [7:0]  fin [0:15];
    logic [7:0]  miso [0:16];

    always #5 clk = ~clk;

    spi_cmd_parser #(.WORK_BYTES(4)) dut (
        .clk(clk), .rst_n(rst_n), .ss(ss), .rx_done(rx_done), .rx_data(rx_data),
        .tx_data(tx_data), .busy(busy), .nonce_valid(nonce_valid), .nonce(nonce),
        .work_valid(work_valid), .work_data(work_data), .found(found)
    );

    always @(posedge clk) begin
        if (work_valid) begin
            wv_cnt  <= wv_cnt + 1;
            wv_data <= work_data;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // tx_data seen at the edge that carries rx_done is what the slave sends in the next byte.
    task automatic send(input logic [7:0] b, input int idx);
        miso[idx+1] = tx_data;
        rx_done = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_done = 1'b0;
        idle(2);
    endtask

    task automatic load(input logic [63:0] v, input int n);
        for (int i = 0; i < n; i++) fin[i] = v[8*(n-1-i) +: 8];
    endtask

    task automatic frame(input int n);
        miso[0] = tx_data;
        ss = 1'b0;
        idle(3);
        for (int i = 0; i < n; i++) send(fin[i], i);
        ss = 1'b1;
        idle(4);
    endtask

    task automatic pulse_nonce(input logic [31:0] v);
        nonce_valid = 1'b1;
        nonce = v;
        @(negedge clk);
        nonce_valid = 1'b0;
        idle(3);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(3);
    endtask

    task automatic test_reset();
        busy = 1'b1;
        do_reset();
        checks++; if (tx_data !== 8'h45) begin errors++; $display("FAIL reset_tx got %h exp 45", tx_data); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL reset_found got %b exp 0", found); end
        checks++; if (work_valid !== 1'b0) begin errors++; $display("FAIL reset_wv got %b exp 0", work_valid); end
        checks++; if (work_data !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", work_data); end
        load(64'h02_00_00_00, 4);
        frame(4);
        for (int i = 0; i < 4; i++) begin
            checks++; if (miso[i] !== 8'h45) begin errors++; $display("FAIL stat_byte%0d got %h exp 45", i, miso[i]); end
        end
        busy = 1'b0;
        idle(3);
    endtask

    task automatic test_work();
        int base;
        base = wv_cnt;
`ifdef WORK_CSUM_EN
        load(64'h01_DE_AD_BE_EF_22, 6);
        frame(6);
`else
        load(64'h01_DE_AD_BE_EF, 5);
        frame(5);
`endif
        checks++; if (wv_cnt - base !== 1) begin errors++; $display("FAIL work_pulses got %0d exp 1", wv_cnt - base); end
        checks++; if (wv_data !== 32'hDEADBEEF) begin errors++; $display("FAIL work_data got %h exp deadbeef", wv_data); end
        checks++; if (tx_data !== 8'h05) begin errors++; $display("FAIL work_status got %h exp 05", tx_data); end
    endtask

    task automatic test_csum();
`ifdef WORK_CSUM_EN
        int base;
        base = wv_cnt;
        load(64'h01_DE_AD_BE_EF_23, 6);
        frame(6);
        checks++; if (wv_cnt - base !== 0) begin errors++; $display("FAIL csum_bad_pulses got %0d exp 0", wv_cnt - base); end
        checks++; if (tx_data !== 8'h15) begin errors++; $display("FAIL csum_bad_status got %h exp 15", tx_data); end
        load(64'h01_DE_AD_BE_EF_22, 6);
        frame(6);
        checks++; if (wv_cnt - base !== 1) begin errors++; $display("FAIL csum_good_pulses got %0d exp 1", wv_cnt - base); end
        checks++; if (tx_data !== 8'h05) begin errors++; $display("FAIL csum_clear_status got %h exp 05", tx_data); end
`else
        load(64'h01_DE_AD_BE_EF_23, 6);
        frame(6);
        checks++; if (tx_data !== 8'h05) begin errors++; $display("FAIL nocsum_status got %h exp 05", tx_data); end
`endif
    endtask

    task automatic test_nonce();
        logic [31:0] got;
        pulse_nonce(32'h12345678);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL nonce_found got %b exp 1", found); end
        checks++; if (tx_data !== 8'h85) begin errors++; $display("FAIL nonce_status got %h exp 85", tx_data); end
        load(64'h03_00_00_00_00_00, 6);
        frame(6);
        got = {miso[2], miso[3], miso[4], miso[5]};
        checks++; if (got !== 32'h12345678) begin errors++; $display("FAIL nonce_read got %h exp 12345678", got); end
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL nonce_clear got %b exp 0", found); end
    endtask

    task automatic test_overrun();
        logic [31:0] got;
        pulse_nonce(32'hAAAA0001);
        pulse_nonce(32'hBBBB0002);
        checks++; if (tx_data !== 8'hA5) begin errors++; $display("FAIL ovr_status got %h exp a5", tx_data); end
        load(64'h03_00_00_00_00_00, 6);
        frame(6);
        got = {miso[2], miso[3], miso[4], miso[5]};
        checks++; if (got !== 32'hAAAA0001) begin errors++; $display("FAIL ovr_read got %h exp aaaa0001", got); end
        checks++; if (tx_data !== 8'h05) begin errors++; $display("FAIL ovr_cleared got %h exp 05", tx_data); end
    endtask

    task automatic test_aborts();
        int base;
        logic [31:0] got;
        base = wv_cnt;
        load(64'h01_AA_BB, 3);
        frame(3);
        checks++; if (wv_cnt - base !== 0) begin errors++; $display("FAIL abort_pulses got %0d exp 0", wv_cnt - base); end
        load(64'h01_01_02_03_04, 5);
`ifdef WORK_CSUM_EN
        fin[5] = 8'h04;
        frame(6);
`else
        frame(5);
`endif
        checks++; if (wv_cnt - base !== 1) begin errors++; $display("FAIL after_abort_pulses got %0d exp 1", wv_cnt - base); end
        checks++; if (wv_data !== 32'h01020304) begin errors++; $display("FAIL after_abort_data got %h exp 01020304", wv_data); end
        pulse_nonce(32'h5555AAAA);
        load(64'h03_00_00_00, 4);
        frame(4);
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL nonce_abort_found got %b exp 1", found); end
        load(64'h03_00_00_00_00_00, 6);
        frame(6);
        got = {miso[2], miso[3], miso[4], miso[5]};
        checks++; if (got !== 32'h5555AAAA) begin errors++; $display("FAIL nonce_abort_read got %h exp 5555aaaa", got); end
    endtask

    task automatic test_drain_and_ignore();
        int base;
        load(64'h7E_00_00_00, 4);
        frame(4);
        checks++; if (miso[2] !== 8'hFF || miso[3] !== 8'hFF) begin errors++; $display("FAIL drain_bytes got %h%h exp ffff", miso[2], miso[3]); end
        base = wv_cnt;
        load(64'h01_DE_AD_BE_EF_22, 6);
        for (int i = 0; i < 6; i++) send(fin[i], i);
        idle(3);
        checks++; if (wv_cnt - base !== 0) begin errors++; $display("FAIL ss_high_ignore got %0d exp 0", wv_cnt - base); end
    endtask

    task automatic test_reset_mid_frame();
        int base;
        pulse_nonce(32'hCAFEF00D);
        ss = 1'b0;
        idle(3);
        send(8'h01, 0);
        send(8'h99, 1);
        rst_n = 1'b0;
        #1;
        checks++; if (found !== 1'b0 || tx_data !== 8'h05 || work_data !== 32'h0) begin
            errors++; $display("FAIL mid_reset got found=%b tx=%h wd=%h exp 0/05/0", found, tx_data, work_data);
        end
        ss = 1'b1;
        idle(2);
        rst_n = 1'b1;
        idle(3);
        base = wv_cnt;
        load(64'h01_11_22_33_44, 5);
`ifdef WORK_CSUM_EN
        fin[5] = 8'h44;
        frame(6);
`else
        frame(5);
`endif
        checks++; if (wv_cnt - base !== 1 || wv_data !== 32'h11223344) begin
            errors++; $display("FAIL post_reset_work got n=%0d d=%h exp 1/11223344", wv_cnt - base, wv_data);
        end
    endtask

    initial begin
        rst_n = 1'b1; ss = 1'b1; rx_done = 1'b0; rx_data = '0;
        busy = 1'b0; nonce_valid = 1'b0; nonce = '0;
        for (int i = 0; i < 16; i++) fin[i] = '0;
        for (int i = 0; i < 17; i++) miso[i] = '0;
        idle(1);
        test_reset();
        test_work();
        test_csum();
        test_nonce();
        test_overrun();
        test_aborts();
        test_drain_and_ignore();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
